dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data-cache controller for the MEM stage.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Serves 32-bit loads and stores from the CPU, and refills or writes back whole lines to data memory over a request/ack handshake.
- Drives the pipeline stall that freezes every stage register, including MEM/WB, while a miss is serviced.

---
 rtl/dcache_ctrl.sv | 125 ++++++++++++
 tb/tb_dcache_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller; hits return in the same cycle, a clean miss costs 1 + memory latency + 1 cycles.
// Backpressure: cpu_stall_o holds the pipeline while a line is written back or refilled over the mem_req_o/mem_ack_i handshake.
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_write_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int OFF_W  = $clog2(LINE_BITS / 8);
    localparam int WSEL_W = OFF_W - 2;
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int BIT_W  = $clog2(LINE_BITS);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
    state_t state_q, state_d;

    logic [LINE_BITS-1:0] data_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic [BIT_W-1:0]  bit_base;
    logic              hit;
    logic              wr_hit;
    logic              fill;
    logic              unused_addr;

    assign idx         = cpu_addr_i[OFF_W +: IDX_W];
    assign tag         = cpu_addr_i[31 -: TAG_W];
    assign wsel        = cpu_addr_i[2 +: WSEL_W];
    assign bit_base    = {wsel, 5'b0};
    assign unused_addr = ^cpu_addr_i[1:0];

    assign hit    = valid_q[idx] && (tag_q[idx] == tag);
    assign wr_hit = (state_q == IDLE) && cpu_req_i && cpu_write_i && hit;
    assign fill   = (state_q == ALLOCATE) && mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (wr_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Data and tags carry no reset; valid gates their use after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fill) begin
                data_q[idx] <= mem_rdata_i;
                tag_q[idx]  <= tag;
            end else if (wr_hit) begin
                data_q[idx][bit_base +: 32] <= cpu_wdata_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cpu_stall_o = 1'b0;
        cpu_rdata_o = '0;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (!cpu_write_i) begin
                            cpu_rdata_o = data_q[idx][bit_base +: 32];
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {tag_q[idx], idx, {OFF_W{1'b0}}};
                mem_wdata_o = data_q[idx];
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {tag, idx, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a fixed-latency line memory model.
module tb_dcache_ctrl;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic         cpu_write;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_req;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;
    logic         ack_m;
    logic         ack_f;

    int checks   = 0;
    int failures = 0;

    logic [31:0] txn_wr[$];
    logic [31:0] txn_addr[$];
    logic [31:0] txn_w2[$];

    assign mem_ack = ack_m | ack_f;

    always #5 clk = ~clk;

    dcache_ctrl #(.NUM_LINES(16), .LINE_BITS(256)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cpu_req_i  (cpu_req),
        .cpu_write_i(cpu_write),
        .cpu_addr_i (cpu_addr),
        .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata),
        .cpu_stall_o(cpu_stall),
        .mem_req_o  (mem_req),
        .mem_write_o(mem_write),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .mem_ack_i  (mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Line at address a holds word i = 0x1000_0000*(tag+1) + i.
    function automatic logic [255:0] line_for(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  base;
        base = 32'h1000_0000 * ((a >> 9) + 32'd1);
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    function automatic int write_count();
        int n = 0;
        foreach (txn_wr[i]) if (txn_wr[i] == 32'd1) n++;
        return n;
    endfunction

    // Memory model: acks after LAT cycles of held request, abandons on reset.
    initial begin
        int cnt;
        cnt = 0;
        ack_m = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (ack_m) begin
                ack_m = 1'b0;
                cnt = 0;
            end
            if (mem_req && !rst) begin
                if (cnt == 0) begin
                    txn_wr.push_back({31'd0, mem_write});
                    txn_addr.push_back(mem_addr);
                    txn_w2.push_back(mem_wdata[95:64]);
                end
                cnt++;
                if (cnt == LAT) begin
                    ack_m = 1'b1;
                    mem_rdata = line_for(mem_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int stalls);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
        stalls = 0;
        rd = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                rd = cpu_rdata;
                break;
            end
            stalls++;
        end
        if (stalls >= 100) check("access_timeout", 32'(stalls), 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          st;
        int          ntx;
        int          nwr;
        int          waited;
        rst = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0; ack_f = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata[31:0] | mem_wdata[255:224], 32'd0);

        // Clean miss then hits
        access(1'b0, 32'h0000_0040, '0, rd, st);
        check("miss_stalls", 32'(st), 32'd4);
        check("miss_rdata", rd, 32'h1000_0000);
        check("miss_txns", 32'(txn_wr.size()), 32'd1);
        check("miss_alloc_wr", txn_wr[0], 32'd0);
        check("miss_alloc_addr", txn_addr[0], 32'h0000_0040);

        access(1'b0, 32'h0000_0044, '0, rd, st);
        check("hit_stalls", 32'(st), 32'd0);
        check("hit_rdata", rd, 32'h1000_0001);

        access(1'b1, 32'h0000_0048, 32'hDEAD_BEEF, rd, st);
        check("st_hit_stalls", 32'(st), 32'd0);
        access(1'b0, 32'h0000_0048, '0, rd, st);
        check("ld_after_st", rd, 32'hDEAD_BEEF);
        check("ld_after_st_stalls", 32'(st), 32'd0);
        check("hit_no_traffic", 32'(txn_wr.size()), 32'd1);

        // Conflict miss on dirty line
        access(1'b0, 32'h0000_0248, '0, rd, st);
        check("dirty_stalls", 32'(st), 32'd7);
        check("dirty_rdata", rd, 32'h2000_0002);
        check("dirty_txns", 32'(txn_wr.size()), 32'd3);
        check("wb_wr", txn_wr[1], 32'd1);
        check("wb_addr", txn_addr[1], 32'h0000_0040);
        check("wb_word2", txn_w2[1], 32'hDEAD_BEEF);
        check("alloc2_wr", txn_wr[2], 32'd0);
        check("alloc2_addr", txn_addr[2], 32'h0000_0240);

        // Dirty the line, miss again, reset during the refill
        access(1'b1, 32'h0000_024C, 32'h1234_5678, rd, st);
        check("st2_stalls", 32'(st), 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0040;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(mem_req && !mem_write) && waited < 50);
        check("reach_alloc", {31'd0, mem_req && !mem_write}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_stall", {31'd0, cpu_stall}, 32'd0);
        nwr = write_count();
        check("pre_rst_wb_count", 32'(nwr), 32'd2);
        access(1'b0, 32'h0000_0040, '0, rd, st);
        check("reload_stalls", 32'(st), 32'd4);
        check("reload_rdata", rd, 32'h1000_0000);
        check("reload_no_wb", 32'(write_count()), 32'(nwr));
        check("reload_alloc_addr", txn_addr[txn_addr.size()-1], 32'h0000_0040);

        // Stray ack in IDLE
        ntx = txn_wr.size();
        @(posedge clk); #1;
        ack_f = 1'b1; mem_rdata = '1;
        @(posedge clk); #1;
        ack_f = 1'b0;
        @(negedge clk);
        check("idle_ack_stall", {31'd0, cpu_stall}, 32'd0);
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);
        check("idle_ack_rdata", cpu_rdata, 32'd0);
        access(1'b0, 32'h0000_0044, '0, rd, st);
        check("idle_ack_hit_stalls", 32'(st), 32'd0);
        check("idle_ack_hit_rdata", rd, 32'h1000_0001);
        check("idle_ack_txns", 32'(txn_wr.size()), 32'(ntx));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
